// File: rtl/pcpi_issuer.sv
// ============================================================================
// Module   : pcpi_issuer
// Brief    : PCPI bus initiator; issues one coprocessor instruction per request
//            and returns OK / ILLEGAL (no responder) / HANG (watchdog) status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcpi_issuer #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int MAX_BUSY_CYCLES = 1023
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        reqValidIn,
  output logic        reqReadyOut,
  input  logic [31:0] reqInstIn,
  input  logic [31:0] reqRs1In,
  input  logic [31:0] reqRs2In,
  output logic        rspValidOut,
  input  logic        rspReadyIn,
  output logic [31:0] rspDataOut,
  output logic        rspWrOut,
  output logic [1:0]  rspStatusOut,
  output logic        pcpiValidOut,
  output logic [31:0] pcpiInstOut,
  output logic [31:0] pcpiRs1Out,
  output logic [31:0] pcpiRs2Out,
  input  logic        pcpiWrIn,
  input  logic [31:0] pcpiRdIn,
  input  logic        pcpiWaitIn,
  input  logic        pcpiReadyIn
);

  localparam int TO_W   = (TIMEOUT_CYCLES  < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int BUSY_W = (MAX_BUSY_CYCLES < 1) ? 1 : $clog2(MAX_BUSY_CYCLES + 1);
  localparam logic [TO_W-1:0]   C_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   C_TO_SAT    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [BUSY_W-1:0] C_BUSY_LAST = BUSY_W'((MAX_BUSY_CYCLES > 0) ? MAX_BUSY_CYCLES - 1 : 0);
  localparam logic [BUSY_W-1:0] C_BUSY_SAT  = BUSY_W'(MAX_BUSY_CYCLES);
  localparam bit                C_BUSY_EN   = (MAX_BUSY_CYCLES != 0);

  localparam logic [1:0] C_ST_OK      = 2'b00;
  localparam logic [1:0] C_ST_ILLEGAL = 2'b01;
  localparam logic [1:0] C_ST_HANG    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic [BUSY_W-1:0] r_busy_cnt;
  logic              w_accept;
  logic              w_finish;
  logic              w_capture;
  logic              w_release;
  logic              w_to_inc;
  logic              w_busy_inc;
  logic [1:0]        w_status;

  assign reqReadyOut = (r_state == S_IDLE);

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Per-cycle priority inside an issue: ready, then wait, then timeout/watchdog.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    w_capture  = 1'b0;
    w_release  = 1'b0;
    w_to_inc   = 1'b0;
    w_busy_inc = 1'b0;
    w_status   = C_ST_OK;
    case (r_state)
      S_IDLE: begin
        if (reqValidIn) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pcpiReadyIn) begin
          w_finish  = 1'b1;
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (pcpiWaitIn) begin
          w_next = S_WAIT;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_finish = 1'b1;
          w_status = C_ST_ILLEGAL;
          w_next   = S_RESP;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (pcpiReadyIn) begin
          w_finish  = 1'b1;
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (C_BUSY_EN && (r_busy_cnt == C_BUSY_LAST)) begin
          w_finish = 1'b1;
          w_status = C_ST_HANG;
          w_next   = S_RESP;
        end else begin
          w_busy_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (rspReadyIn) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_to_cnt     <= '0;
      r_busy_cnt   <= '0;
      pcpiValidOut <= 1'b0;
      pcpiInstOut  <= '0;
      pcpiRs1Out   <= '0;
      pcpiRs2Out   <= '0;
      rspValidOut  <= 1'b0;
      rspDataOut   <= '0;
      rspWrOut     <= 1'b0;
      rspStatusOut <= '0;
    end else begin
      if (w_accept) begin
        pcpiValidOut <= 1'b1;
        pcpiInstOut  <= reqInstIn;
        pcpiRs1Out   <= reqRs1In;
        pcpiRs2Out   <= reqRs2In;
        r_to_cnt     <= '0;
        r_busy_cnt   <= '0;
      end
      if (w_to_inc && (r_to_cnt != C_TO_SAT))
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_busy_inc && (r_busy_cnt != C_BUSY_SAT))
        r_busy_cnt <= r_busy_cnt + 1'b1;
      // Result fields stay zero unless a responder actually completed.
      if (w_finish) begin
        pcpiValidOut <= 1'b0;
        pcpiInstOut  <= '0;
        pcpiRs1Out   <= '0;
        pcpiRs2Out   <= '0;
        rspValidOut  <= 1'b1;
        rspDataOut   <= w_capture ? pcpiRdIn : 32'd0;
        rspWrOut     <= w_capture ? pcpiWrIn : 1'b0;
        rspStatusOut <= w_status;
      end
      if (w_release) begin
        rspValidOut  <= 1'b0;
        rspDataOut   <= '0;
        rspWrOut     <= 1'b0;
        rspStatusOut <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcpi_issuer.sv
// ============================================================================
// Module   : tb_pcpi_issuer
// Brief    : Directed bench for pcpi_issuer with a transaction-level outcome model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcpi_issuer;
  localparam int TO = 16;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValidIn = 1'b0, reqReadyOut;
  logic [31:0] reqInstIn = '0, reqRs1In = '0, reqRs2In = '0;
  logic        rspValidOut, rspReadyIn = 1'b0, rspWrOut;
  logic [31:0] rspDataOut;
  logic [1:0]  rspStatusOut;
  logic        pcpiValidOut;
  logic [31:0] pcpiInstOut, pcpiRs1Out, pcpiRs2Out;
  logic        pcpiWrIn = 1'b0, pcpiWaitIn = 1'b0, pcpiReadyIn = 1'b0;
  logic [31:0] pcpiRdIn = '0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic        exp_req_ready, exp_pcpi_valid, exp_rsp_valid, exp_wr;
  logic [31:0] exp_inst, exp_rs1, exp_rs2, exp_data;
  logic [1:0]  exp_status;

  always #5 clk = ~clk;

  pcpi_issuer #(.TIMEOUT_CYCLES(TO), .MAX_BUSY_CYCLES(MB)) dut (
    .clkIn(clk), .rstIn(rst),
    .reqValidIn(reqValidIn), .reqReadyOut(reqReadyOut),
    .reqInstIn(reqInstIn), .reqRs1In(reqRs1In), .reqRs2In(reqRs2In),
    .rspValidOut(rspValidOut), .rspReadyIn(rspReadyIn),
    .rspDataOut(rspDataOut), .rspWrOut(rspWrOut), .rspStatusOut(rspStatusOut),
    .pcpiValidOut(pcpiValidOut), .pcpiInstOut(pcpiInstOut),
    .pcpiRs1Out(pcpiRs1Out), .pcpiRs2Out(pcpiRs2Out),
    .pcpiWrIn(pcpiWrIn), .pcpiRdIn(pcpiRdIn),
    .pcpiWaitIn(pcpiWaitIn), .pcpiReadyIn(pcpiReadyIn)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reqReadyOut",  {31'd0, reqReadyOut},  {31'd0, exp_req_ready});
      chk("pcpiValidOut", {31'd0, pcpiValidOut}, {31'd0, exp_pcpi_valid});
      chk("pcpiInstOut",  pcpiInstOut, exp_inst);
      chk("pcpiRs1Out",   pcpiRs1Out,  exp_rs1);
      chk("pcpiRs2Out",   pcpiRs2Out,  exp_rs2);
      chk("rspValidOut",  {31'd0, rspValidOut}, {31'd0, exp_rsp_valid});
      chk("rspDataOut",   rspDataOut,  exp_data);
      chk("rspWrOut",     {31'd0, rspWrOut},     {31'd0, exp_wr});
      chk("rspStatusOut", {30'd0, rspStatusOut}, {30'd0, exp_status});
    end
  end

  // Outcome of one transaction: the issue cycle k (1 = first valid cycle) on
  // which it ends, and the resulting status. wk/rk = 0 means never.
  task automatic model(input int wk, input int rk, output int fin, output logic [1:0] st);
    int wait_eff;
    wait_eff = (wk == 0) ? 32'h4000_0000 : wk;
    if (rk != 0 && rk <= wait_eff && rk <= TO) begin
      fin = rk; st = 2'b00;
    end else if (wk != 0 && wk <= TO) begin
      if (rk != 0 && rk <= wk + MB) begin fin = rk;      st = 2'b00; end
      else                          begin fin = wk + MB; st = 2'b10; end
    end else begin
      fin = TO; st = 2'b01;
    end
  endtask

  task automatic set_idle_exp();
    exp_req_ready = 1'b1; exp_pcpi_valid = 1'b0; exp_rsp_valid = 1'b0; exp_wr = 1'b0;
    exp_inst = '0; exp_rs1 = '0; exp_rs2 = '0; exp_data = '0; exp_status = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reqValidIn = 1'b0;
      pcpiReadyIn = (i == 0); pcpiWaitIn = (i == 1);
      set_idle_exp();
      @(posedge clk); #1;
    end
    pcpiReadyIn = 1'b0; pcpiWaitIn = 1'b0;
  endtask

  // Entered and left at #1 after the edge that starts an IDLE cycle.
  task automatic run_txn(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int wk, input int rk, input logic [31:0] rd, input logic wr,
                         input int rsp_hold, input bit hold_req,
                         input int lit_fin, input logic [1:0] lit_st);
    int fin, hi;
    logic [1:0] st;
    model(wk, rk, fin, st);
    hi = 0;
    reqValidIn = 1'b1; reqInstIn = inst; reqRs1In = rs1; reqRs2In = rs2;
    pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b0; rspReadyIn = 1'b0;
    set_idle_exp();
    for (int k = 1; k <= fin; k++) begin
      @(posedge clk); #1;
      reqValidIn  = hold_req;
      pcpiWaitIn  = (wk != 0 && k >= wk);
      pcpiReadyIn = (k == rk);
      pcpiRdIn    = (k == rk) ? rd : ~rd;
      pcpiWrIn    = (k == rk) ? wr : ~wr;
      exp_req_ready = 1'b0; exp_pcpi_valid = 1'b1;
      exp_inst = inst; exp_rs1 = rs1; exp_rs2 = rs2;
      exp_rsp_valid = 1'b0; exp_data = '0; exp_wr = 1'b0; exp_status = 2'b00;
      @(negedge clk);
      if (pcpiValidOut) hi++;
    end
    for (int j = 0; j <= rsp_hold; j++) begin
      @(posedge clk); #1;
      pcpiWaitIn  = (j == 1);
      pcpiReadyIn = (j == 2);
      pcpiRdIn    = 32'hDEAD_BEEF; pcpiWrIn = 1'b1;
      rspReadyIn  = (j == rsp_hold);
      exp_req_ready = 1'b0; exp_pcpi_valid = 1'b0;
      exp_inst = '0; exp_rs1 = '0; exp_rs2 = '0;
      exp_rsp_valid = 1'b1;
      exp_data   = (st == 2'b00) ? rd : 32'd0;
      exp_wr     = (st == 2'b00) ? wr : 1'b0;
      exp_status = st;
      if (j == 0) begin
        @(negedge clk);
        chk("lit_status", {30'd0, rspStatusOut}, {30'd0, lit_st});
        chk("lit_valid_cycles", hi, lit_fin);
      end
    end
    @(posedge clk); #1;
    rspReadyIn = 1'b0; pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b0;
    reqValidIn = hold_req;
    set_idle_exp();
  endtask

  // Start a transaction, then hit reset part-way through issue cycle `cut`.
  task automatic abort_txn(input int wk, input int rk, input int cut);
    int fin;
    logic [1:0] st;
    model(wk, rk, fin, st);
    chk_en = 1'b0;
    reqValidIn = 1'b1; reqInstIn = 32'h0000_1234;
    @(posedge clk); #1;
    reqValidIn = 1'b0;
    for (int k = 1; k <= cut; k++) begin
      pcpiWaitIn  = (wk != 0 && k >= wk) && (k <= fin);
      pcpiReadyIn = (k == rk);
      pcpiRdIn    = 32'h1111_2222;
      if (k < cut) begin @(posedge clk); #1; end
    end
    pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b0;
    #1;
    chk("pre_rst_pcpi_valid", {31'd0, pcpiValidOut}, {31'd0, (cut <= fin)});
    chk("pre_rst_rsp_valid",  {31'd0, rspValidOut},  {31'd0, (cut > fin)});
    #1 rst = 1'b1;
    #1;
    chk("rst_pcpi_valid", {31'd0, pcpiValidOut}, 32'd0);
    chk("rst_rsp_valid",  {31'd0, rspValidOut},  32'd0);
    chk("rst_req_ready",  {31'd0, reqReadyOut},  32'd1);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    set_idle_exp();
    chk_en = 1'b1;
  endtask

  initial begin
    set_idle_exp();
    @(posedge clk); #1;
    chk("reset_req_ready",  {31'd0, reqReadyOut},  32'd1);
    chk("reset_pcpi_valid", {31'd0, pcpiValidOut}, 32'd0);
    chk("reset_rsp_valid",  {31'd0, rspValidOut},  32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);

    run_txn(32'h1020_8053, 32'h4000_0000, 32'h40C0_0000, 0, 1, 32'h40C0_0000, 1'b1, 0, 1'b0, 1, 2'b00);
    run_txn(32'h1020_8053, 32'h3F80_0000, 32'h3F80_0000, 1, 6, 32'h3F80_0000, 1'b1, 0, 1'b0, 6, 2'b00);
    idle(1);
    run_txn(32'h0000_00AB, 32'h0000_0001, 32'h0000_0002, 0, 0, 32'h1234_5678, 1'b1, 0, 1'b0, 16, 2'b01);
    run_txn(32'h0200_0033, 32'hAAAA_5555, 32'h5555_AAAA, 1, 0, 32'h1234_5678, 1'b1, 0, 1'b0, 9, 2'b10);
    run_txn(32'h0200_0033, 32'hAAAA_5555, 32'h5555_AAAA, 1, 9, 32'hCAFE_F00D, 1'b1, 0, 1'b0, 9, 2'b00);
    run_txn(32'h0000_0F0F, 32'h0000_0003, 32'h0000_0004, 0, 16, 32'h0BAD_CAFE, 1'b1, 1, 1'b0, 16, 2'b00);
    run_txn(32'h0000_0E0E, 32'h0000_0005, 32'h0000_0006, 3, 3, 32'h7777_0000, 1'b0, 2, 1'b0, 3, 2'b00);
    run_txn(32'h0000_0D0D, 32'h0000_0007, 32'h0000_0008, 16, 0, 32'h7777_0001, 1'b1, 0, 1'b0, 24, 2'b10);

    run_txn(32'h1020_8053, 32'h4000_0000, 32'h4040_0000, 0, 2, 32'h40C0_0000, 1'b1, 10, 1'b1, 2, 2'b00);
    run_txn(32'h5555_0001, 32'h0000_0009, 32'h0000_000A, 0, 1, 32'h0000_0042, 1'b0, 0, 1'b0, 1, 2'b00);
    idle(1);

    abort_txn(1, 0, 5);
    idle(2);
    abort_txn(0, 1, 3);
    idle(1);
    run_txn(32'h1020_8053, 32'h4000_0000, 32'h40C0_0000, 0, 1, 32'h40C0_0000, 1'b1, 0, 1'b0, 1, 2'b00);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
